// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding
// and the data-request error predicate.
package unified_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_DM = 3'd2,
        ST_RESP    = 3'd3,
        ST_HALTED  = 3'd4
    } arb_state_t;

    // A data request is illegal when it asks for both read and write,
    // or when alignment checking is on and the address is odd.
    function automatic logic dm_req_bad(
        input logic        rd,
        input logic        wr,
        input logic [15:0] addr,
        input logic        align_chk
    );
        return (rd & wr) | (align_chk & addr[0]);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_mem_lat_cnt.sv
// Access-length counter: counts 0..MEM_LAT-1 while enabled and flags the
// final held cycle of a memory access.
module mem_lat_cnt #(
    parameter int MEM_LAT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    logic [CW-1:0] r_cnt;

    // Count held cycles of the current access, wrapping on the last one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_last = i_en & (r_cnt == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one fixed-latency single-port memory
// between instruction fetch and data load/store. Data wins conflicts,
// each access is followed by a one-cycle response, HALT freezes fetch.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = 4,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic [15:0] o_if_rdata,
    output logic        o_if_done,
    output logic        o_if_stall,
    input  logic        i_dm_rd,
    input  logic        i_dm_wr,
    input  logic [15:0] i_dm_addr,
    input  logic [15:0] i_dm_wdata,
    output logic [15:0] o_dm_rdata,
    output logic        o_dm_done,
    output logic        o_dm_err,
    output logic        o_dm_stall,
    input  logic        i_halt,
    output logic        o_halted,
    output logic        o_mem_en,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    arb_state_t  r_state;
    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_if_rdata;
    logic [15:0] r_dm_rdata;
    logic        r_if_done;
    logic        r_dm_done;
    logic        r_dm_err;
    logic        r_halted;

    logic w_dm_req;
    logic w_dm_bad;
    logic w_busy;
    logic w_last;

    assign w_dm_req = i_dm_rd | i_dm_wr;
    assign w_dm_bad = dm_req_bad(i_dm_rd, i_dm_wr, i_dm_addr, ALIGN_CHK);
    assign w_busy   = (r_state == ST_BUSY_IF) | (r_state == ST_BUSY_DM);

    mem_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~w_busy),
        .i_en    (w_busy),
        .o_last  (w_last)
    );

    // Arbitration FSM: grants in IDLE, holds the strobe through BUSY,
    // pulses the winner's done in RESP, and parks in HALTED until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_if_rdata  <= 16'h0000;
            r_dm_rdata  <= 16'h0000;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_dm_err    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_dm_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_req && w_dm_bad) begin
                        r_state   <= ST_RESP;
                        r_dm_done <= 1'b1;
                        r_dm_err  <= 1'b1;
                    end else if (w_dm_req) begin
                        r_state     <= ST_BUSY_DM;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= i_dm_wr;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                    end else if (i_if_req && !i_halt) begin
                        r_state    <= ST_BUSY_IF;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= i_if_addr;
                    end else if (i_halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY_IF: begin
                    if (w_last) begin
                        r_state    <= ST_RESP;
                        r_mem_en   <= 1'b0;
                        r_if_done  <= 1'b1;
                        r_if_rdata <= i_mem_rdata;
                    end else begin
                        r_state <= ST_BUSY_IF;
                    end
                end
                ST_BUSY_DM: begin
                    if (w_last) begin
                        r_state   <= ST_RESP;
                        r_mem_en  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_dm_done <= 1'b1;
                        // Stores leave the last load value untouched.
                        if (!r_mem_wr) begin
                            r_dm_rdata <= i_mem_rdata;
                        end else begin
                            r_dm_rdata <= r_dm_rdata;
                        end
                    end else begin
                        r_state <= ST_BUSY_DM;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_if_done   = r_if_done;
    assign o_dm_done   = r_dm_done;
    assign o_dm_err    = r_dm_err;
    assign o_halted    = r_halted;
    assign o_if_stall  = i_if_req & ~r_if_done;
    assign o_dm_stall  = w_dm_req & ~r_dm_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (MEM_LAT=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_err;
    logic        dm_stall;
    logic        halt;
    logic        halted;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks;
    int errors;

    unified_mem_arbiter #(
        .MEM_LAT   (4),
        .ALIGN_CHK (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_done   (if_done),
        .o_if_stall  (if_stall),
        .i_dm_rd     (dm_rd),
        .i_dm_wr     (dm_wr),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_rdata  (dm_rdata),
        .o_dm_done   (dm_done),
        .o_dm_err    (dm_err),
        .o_dm_stall  (dm_stall),
        .i_halt      (halt),
        .o_halted    (halted),
        .o_mem_en    (mem_en),
        .o_mem_wr    (mem_wr),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge of the next cycle.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"},   {15'h0, mem_en},  16'h0000);
        chk({tag, "_mem_wr"},   {15'h0, mem_wr},  16'h0000);
        chk({tag, "_mem_addr"}, mem_addr,         16'h0000);
        chk({tag, "_mem_wd"},   mem_wdata,        16'h0000);
        chk({tag, "_if_done"},  {15'h0, if_done}, 16'h0000);
        chk({tag, "_dm_done"},  {15'h0, dm_done}, 16'h0000);
        chk({tag, "_dm_err"},   {15'h0, dm_err},  16'h0000);
        chk({tag, "_halted"},   {15'h0, halted},  16'h0000);
        chk({tag, "_if_rdata"}, if_rdata,         16'h0000);
        chk({tag, "_dm_rdata"}, dm_rdata,         16'h0000);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 16'h0000;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = 16'h0000;
        dm_wdata  = 16'h0000;
        halt      = 1'b0;
        mem_rdata = 16'h0000;

        // Reset state
        repeat (2) cyc();
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // 1) Fetch, no conflict
        if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hA5C3;
        #1;
        chk("f_c0_stall", {15'h0, if_stall}, 16'h0001);
        chk("f_c0_en",    {15'h0, mem_en},   16'h0000);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("f_busy_en",   {15'h0, mem_en},  16'h0001);
            chk("f_busy_wr",   {15'h0, mem_wr},  16'h0000);
            chk("f_busy_addr", mem_addr,         16'h0010);
            chk("f_busy_done", {15'h0, if_done}, 16'h0000);
        end
        cyc();
        chk("f_c5_done",  {15'h0, if_done},  16'h0001);
        chk("f_c5_rdata", if_rdata,          16'hA5C3);
        chk("f_c5_stall", {15'h0, if_stall}, 16'h0000);
        chk("f_c5_en",    {15'h0, mem_en},   16'h0000);
        if_req = 1'b0;
        cyc();
        chk("f_c6_done",  {15'h0, if_done}, 16'h0000);
        chk("f_c6_hold",  if_rdata,         16'hA5C3);

        // 2) Conflict: DM wins, IF follows after DM's response
        if_req = 1'b1; if_addr = 16'h0020;
        dm_rd = 1'b1; dm_addr = 16'h0200; mem_rdata = 16'h1234;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("c_dm_en",    {15'h0, mem_en},   16'h0001);
            chk("c_dm_addr",  mem_addr,          16'h0200);
            chk("c_if_stall", {15'h0, if_stall}, 16'h0001);
        end
        cyc();
        chk("c_c5_dmdone", {15'h0, dm_done}, 16'h0001);
        chk("c_c5_dmrd",   dm_rdata,         16'h1234);
        chk("c_c5_ifdone", {15'h0, if_done}, 16'h0000);
        dm_rd = 1'b0; mem_rdata = 16'h5678;
        cyc();
        chk("c_c6_en", {15'h0, mem_en}, 16'h0000);
        for (int k = 7; k <= 10; k++) begin
            cyc();
            chk("c_if_en",   {15'h0, mem_en},  16'h0001);
            chk("c_if_addr", mem_addr,         16'h0020);
            chk("c_if_done", {15'h0, if_done}, 16'h0000);
        end
        cyc();
        chk("c_c11_ifdone", {15'h0, if_done}, 16'h0001);
        chk("c_c11_ifrd",   if_rdata,         16'h5678);
        chk("c_c11_dmhold", dm_rdata,         16'h1234);
        if_req = 1'b0;
        cyc();

        // 3) Store
        dm_wr = 1'b1; dm_addr = 16'h0044; dm_wdata = 16'hBEEF; mem_rdata = 16'h9999;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("s_en",   {15'h0, mem_en}, 16'h0001);
            chk("s_wr",   {15'h0, mem_wr}, 16'h0001);
            chk("s_addr", mem_addr,        16'h0044);
            chk("s_data", mem_wdata,       16'hBEEF);
        end
        cyc();
        chk("s_c5_done",  {15'h0, dm_done}, 16'h0001);
        chk("s_c5_err",   {15'h0, dm_err},  16'h0000);
        chk("s_c5_rhold", dm_rdata,         16'h1234);
        dm_wr = 1'b0;
        cyc();

        // 4a) Misaligned load is rejected without a memory access
        dm_rd = 1'b1; dm_addr = 16'h0003;
        cyc();
        chk("e1_done", {15'h0, dm_done}, 16'h0001);
        chk("e1_err",  {15'h0, dm_err},  16'h0001);
        chk("e1_en",   {15'h0, mem_en},  16'h0000);
        dm_rd = 1'b0;
        cyc();
        chk("e1_c2_done", {15'h0, dm_done}, 16'h0000);
        chk("e1_c2_en",   {15'h0, mem_en},  16'h0000);

        // 4b) Read and write together is rejected
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0010;
        cyc();
        chk("e2_done", {15'h0, dm_done}, 16'h0001);
        chk("e2_err",  {15'h0, dm_err},  16'h0001);
        chk("e2_en",   {15'h0, mem_en},  16'h0000);
        dm_rd = 1'b0; dm_wr = 1'b0;
        cyc();
        chk("e2_c2_err", {15'h0, dm_err}, 16'h0000);

        // 5) Halt raised during a fetch
        if_req = 1'b1; if_addr = 16'h0030; mem_rdata = 16'h0F0F;
        cyc();
        chk("h_c1_en", {15'h0, mem_en}, 16'h0001);
        cyc();
        halt = 1'b1;
        cyc();
        cyc();
        chk("h_c4_en", {15'h0, mem_en}, 16'h0001);
        cyc();
        chk("h_c5_done",  {15'h0, if_done}, 16'h0001);
        chk("h_c5_rdata", if_rdata,         16'h0F0F);
        if_req = 1'b0;
        cyc();
        chk("h_c6_halted", {15'h0, halted}, 16'h0000);
        cyc();
        chk("h_c7_halted", {15'h0, halted}, 16'h0001);
        if_req = 1'b1; if_addr = 16'h0040;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("h_ignore_en", {15'h0, mem_en},  16'h0000);
        end
        chk("h_end_halted", {15'h0, halted}, 16'h0001);
        chk("h_end_stall",  {15'h0, if_stall}, 16'h0001);
        if_req = 1'b0; halt = 1'b0;

        // 6) Reset during a data access, then a fresh fetch
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        dm_rd = 1'b1; dm_addr = 16'h0100; mem_rdata = 16'h2222;
        cyc();
        cyc();
        chk("r_c2_en", {15'h0, mem_en}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("r_async");
        dm_rd = 1'b0;
        cyc();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 16'h0050; mem_rdata = 16'h7777;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("r_f_en",   {15'h0, mem_en}, 16'h0001);
            chk("r_f_addr", mem_addr,        16'h0050);
        end
        cyc();
        chk("r_f_done",  {15'h0, if_done}, 16'h0001);
        chk("r_f_rdata", if_rdata,         16'h7777);
        chk("r_f_dmrd",  dm_rdata,         16'h0000);
        if_req = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
